// File: rtl/gshare_pkg.sv
// Types and constants shared by the gshare predictor and its BTB.
`include "sys_defs.svh"

package gshare_pkg;

    localparam int ADDR_W            = `ADDR_BITS;
    localparam int DEFAULT_HIST_BITS = `BRANCH_HISTORY_REG_SZ;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef struct packed {
        logic  valid;
        addr_t tag;
        addr_t target;
    } btb_entry_t;

    // Weakly-not-taken is the counter value just below the taken threshold.
    function automatic int unsigned ctr_weak_nt(input int unsigned ctr_bits);
        return (32'd1 << (ctr_bits - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/gshare_btb.sv
// Direct-mapped branch target buffer: N_LANES combinational read ports and
// one write port; writes become visible on the cycle after the edge.
module gshare_btb
    import gshare_pkg::*;
#(
    parameter int N_LANES = 2,
    parameter int SETS    = 16
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [N_LANES-1:0][ADDR_W-1:0]   rd_pc_i,
    output logic [N_LANES-1:0]               rd_hit_o,
    output logic [N_LANES-1:0][ADDR_W-1:0]   rd_target_o,
    input  logic                             wr_en_i,
    input  logic [ADDR_W-1:0]                wr_pc_i,
    input  logic [ADDR_W-1:0]                wr_target_i
);

    localparam int IDX_BITS  = $clog2(SETS);
    localparam int TAG_SHIFT = IDX_BITS + 2;

    logic [SETS-1:0]     valid_q;
    addr_t               tag_q    [SETS];
    addr_t               target_q [SETS];
    logic [IDX_BITS-1:0] wr_idx;
    btb_entry_t          rd_entry [N_LANES];

    assign wr_idx = wr_pc_i[IDX_BITS+1:2];

    // NOTE: sequential state is always assigned with <= so every flop samples
    // pre-edge values; that is what gives read-before-write on a shared entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // NOTE: the tag/target storage is deliberately left unreset; every read is
    // qualified by its valid bit, so clearing valid_q alone empties the BTB.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            tag_q[wr_idx]    <= wr_pc_i >> TAG_SHIFT;
            target_q[wr_idx] <= wr_target_i;
        end
    end

    // NOTE: every output of this block gets a default before the loop so no
    // path can leave a value unassigned and infer a latch.
    always_comb begin
        rd_hit_o    = '0;
        rd_target_o = '0;
        for (int k = 0; k < N_LANES; k++) begin
            rd_entry[k] = '{
                valid:  valid_q[rd_pc_i[k][IDX_BITS+1:2]],
                tag:    tag_q[rd_pc_i[k][IDX_BITS+1:2]],
                target: target_q[rd_pc_i[k][IDX_BITS+1:2]]
            };
            rd_hit_o[k]    = rd_entry[k].valid &&
                             (rd_entry[k].tag == (rd_pc_i[k] >> TAG_SHIFT));
            rd_target_o[k] = rd_entry[k].target;
        end
    end

endmodule

// File: rtl/sys_defs.svh
// Shared system sizing: address width and default branch history length.
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH

`define ADDR_BITS             32
`define BRANCH_HISTORY_REG_SZ 8

`endif

// File: rtl/gshare_predictor.sv
// Multi-lane gshare direction predictor with a shared BTB, speculative global
// history and mispredict recovery from the resolved branch's history.
module gshare_predictor
    import gshare_pkg::*;
#(
    parameter int N_LANES   = 2,
    parameter int HIST_BITS = DEFAULT_HIST_BITS,
    parameter int CTR_BITS  = 2,
    parameter int BTB_SETS  = 16
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [N_LANES-1:0]                 rd_valid,
    input  logic [N_LANES-1:0][ADDR_W-1:0]     rd_pc,
    output logic [N_LANES-1:0]                 pred_valid,
    output logic [N_LANES-1:0]                 pred_taken,
    output logic [N_LANES-1:0][ADDR_W-1:0]     pred_target,
    output logic [N_LANES-1:0][HIST_BITS-1:0]  pred_bhr,
    input  logic                               wr_en,
    input  logic [ADDR_W-1:0]                  wr_pc,
    input  logic [ADDR_W-1:0]                  wr_target,
    input  logic [HIST_BITS-1:0]               wr_bhr,
    input  logic                               wr_taken,
    input  logic                               wr_mispredict,
    output logic [HIST_BITS-1:0]               ghr
);

    localparam int                 PHT_DEPTH = 1 << HIST_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_weak_nt(CTR_BITS));

    logic [HIST_BITS-1:0]             ghr_q;
    logic [HIST_BITS-1:0]             ghr_d;
    logic [HIST_BITS-1:0]             spec_hist;
    logic [CTR_BITS-1:0]              pht_q [PHT_DEPTH];
    logic [N_LANES-1:0]               btb_hit;
    logic [N_LANES-1:0][ADDR_W-1:0]   btb_target;
    logic [HIST_BITS-1:0]             wr_idx;
    logic [CTR_BITS-1:0]              wr_ctr;

    gshare_btb #(
        .N_LANES (N_LANES),
        .SETS    (BTB_SETS)
    ) u_btb (
        .clock       (clock),
        .reset       (reset),
        .rd_pc_i     (rd_pc),
        .rd_hit_o    (btb_hit),
        .rd_target_o (btb_target),
        .wr_en_i     (wr_en & wr_taken),
        .wr_pc_i     (wr_pc),
        .wr_target_i (wr_target)
    );

    // Walk lanes oldest to youngest; each predicted branch shifts its outcome
    // into the history seen by younger lanes, and a taken one squashes them.
    always_comb begin
        logic [HIST_BITS-1:0] hist;
        logic [HIST_BITS-1:0] idx;
        logic                 squash;
        hist        = ghr_q;
        idx         = '0;
        squash      = 1'b0;
        pred_valid  = '0;
        pred_taken  = '0;
        pred_target = '0;
        pred_bhr    = '0;
        for (int k = 0; k < N_LANES; k++) begin
            idx            = rd_pc[k][HIST_BITS+1:2] ^ hist;
            pred_bhr[k]    = hist;
            pred_valid[k]  = rd_valid[k] & ~squash;
            pred_taken[k]  = btb_hit[k] & pht_q[idx][CTR_BITS-1];
            pred_target[k] = btb_hit[k] ? btb_target[k] : '0;
            if (pred_valid[k] && btb_hit[k]) begin
                hist = {hist[HIST_BITS-2:0], pred_taken[k]};
            end
            squash = squash | (pred_valid[k] & pred_taken[k]);
        end
        spec_hist = hist;
    end

    always_comb begin
        ghr_d = spec_hist;
        if (wr_en && wr_mispredict) begin
            ghr_d = {wr_bhr[HIST_BITS-2:0], wr_taken};
        end
    end

    assign wr_idx = wr_pc[HIST_BITS+1:2] ^ wr_bhr;
    assign wr_ctr = pht_q[wr_idx];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ghr_q <= '0;
            for (int i = 0; i < PHT_DEPTH; i++) begin
                pht_q[i] <= CTR_INIT;
            end
        end else begin
            ghr_q <= ghr_d;
            if (wr_en) begin
                if (wr_taken && (wr_ctr != CTR_MAX)) begin
                    pht_q[wr_idx] <= wr_ctr + 1'b1;
                end else if (!wr_taken && (wr_ctr != '0)) begin
                    pht_q[wr_idx] <= wr_ctr - 1'b1;
                end
            end
        end
    end

    assign ghr = ghr_q;

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed, table-driven bench for gshare_predictor (2 lanes, 4-bit history,
// 2-bit counters, 16-set BTB) with hand-computed expectations.
module tb_gshare_predictor;
    import gshare_pkg::*;

    localparam int NL   = 2;
    localparam int HB   = 4;
    localparam int CB   = 2;
    localparam int BS   = 16;
    localparam int NVEC = 13;

    logic                      clock = 1'b0;
    logic                      reset = 1'b0;
    logic [NL-1:0]             rd_valid;
    logic [NL-1:0][ADDR_W-1:0] rd_pc;
    logic [NL-1:0]             pred_valid;
    logic [NL-1:0]             pred_taken;
    logic [NL-1:0][ADDR_W-1:0] pred_target;
    logic [NL-1:0][HB-1:0]     pred_bhr;
    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_pc;
    logic [ADDR_W-1:0]         wr_target;
    logic [HB-1:0]             wr_bhr;
    logic                      wr_taken;
    logic                      wr_mispredict;
    logic [HB-1:0]             ghr;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [1:0]  rd_valid;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic        wr_en;
        logic [31:0] wr_pc;
        logic [31:0] wr_target;
        logic [3:0]  wr_bhr;
        logic        wr_taken;
        logic        wr_mis;
        logic [1:0]  exp_valid;
        logic [1:0]  exp_taken;
        logic [31:0] exp_tgt0;
        logic [31:0] exp_tgt1;
        logic [3:0]  exp_bhr0;
        logic [3:0]  exp_bhr1;
        logic [3:0]  exp_ghr_next;
    } vec_t;

    vec_t vecs [NVEC];

    gshare_predictor #(
        .N_LANES   (NL),
        .HIST_BITS (HB),
        .CTR_BITS  (CB),
        .BTB_SETS  (BS)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .rd_valid      (rd_valid),
        .rd_pc         (rd_pc),
        .pred_valid    (pred_valid),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .pred_bhr      (pred_bhr),
        .wr_en         (wr_en),
        .wr_pc         (wr_pc),
        .wr_target     (wr_target),
        .wr_bhr        (wr_bhr),
        .wr_taken      (wr_taken),
        .wr_mispredict (wr_mispredict),
        .ghr           (ghr)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic idle_writes();
        wr_en = 1'b0; wr_pc = '0; wr_target = '0; wr_bhr = '0;
        wr_taken = 1'b0; wr_mispredict = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        //            rdv    pc0     pc1    wen  wr_pc   wr_tgt  bhr tk  mis  evld   etkn   etgt0    etgt1   bhr0  bhr1  ghr'
        vecs[0]  = '{2'b01, 32'h40, 32'h44, 1'b1, 32'h40, 32'h100, 4'h0, 1'b1, 1'b0, 2'b01, 2'b00, 32'h0,   32'h0,   4'h0, 4'h0, 4'h0};
        vecs[1]  = '{2'b00, 32'h40, 32'h44, 1'b1, 32'h40, 32'h100, 4'h0, 1'b1, 1'b0, 2'b00, 2'b01, 32'h100, 32'h0,   4'h0, 4'h0, 4'h0};
        vecs[2]  = '{2'b00, 32'h40, 32'h44, 1'b1, 32'h40, 32'h100, 4'h0, 1'b1, 1'b0, 2'b00, 2'b01, 32'h100, 32'h0,   4'h0, 4'h0, 4'h0};
        vecs[3]  = '{2'b11, 32'h40, 32'h44, 1'b0, 32'h0,  32'h0,   4'h0, 1'b0, 1'b0, 2'b01, 2'b01, 32'h100, 32'h0,   4'h0, 4'h1, 4'h1};
        vecs[4]  = '{2'b00, 32'h40, 32'h44, 1'b1, 32'h48, 32'h180, 4'h0, 1'b1, 1'b0, 2'b00, 2'b00, 32'h100, 32'h0,   4'h1, 4'h1, 4'h1};
        vecs[5]  = '{2'b00, 32'h40, 32'h44, 1'b1, 32'h4C, 32'h200, 4'h6, 1'b1, 1'b0, 2'b00, 2'b00, 32'h100, 32'h0,   4'h1, 4'h1, 4'h1};
        vecs[6]  = '{2'b00, 32'h40, 32'h44, 1'b1, 32'h3C, 32'h300, 4'h1, 1'b1, 1'b1, 2'b00, 2'b00, 32'h100, 32'h0,   4'h1, 4'h1, 4'h3};
        vecs[7]  = '{2'b11, 32'h48, 32'h4C, 1'b0, 32'h0,  32'h0,   4'h0, 1'b0, 1'b0, 2'b11, 2'b10, 32'h180, 32'h200, 4'h3, 4'h6, 4'hD};
        vecs[8]  = '{2'b11, 32'h4C, 32'h44, 1'b1, 32'h3C, 32'h300, 4'hA, 1'b1, 1'b1, 2'b01, 2'b01, 32'h200, 32'h0,   4'hD, 4'hB, 4'h5};
        vecs[9]  = '{2'b00, 32'h40, 32'h44, 1'b0, 32'h3C, 32'h300, 4'h0, 1'b0, 1'b1, 2'b00, 2'b01, 32'h100, 32'h0,   4'h5, 4'h5, 4'h5};
        vecs[10] = '{2'b00, 32'h40, 32'h44, 1'b1, 32'h48, 32'h3F0, 4'h5, 1'b0, 1'b0, 2'b00, 2'b01, 32'h100, 32'h0,   4'h5, 4'h5, 4'h5};
        vecs[11] = '{2'b00, 32'h40, 32'h44, 1'b1, 32'h48, 32'h3F0, 4'h5, 1'b0, 1'b0, 2'b00, 2'b01, 32'h100, 32'h0,   4'h5, 4'h5, 4'h5};
        vecs[12] = '{2'b11, 32'h48, 32'h4C, 1'b0, 32'h0,  32'h0,   4'h0, 1'b0, 1'b0, 2'b11, 2'b00, 32'h180, 32'h200, 4'h5, 4'hA, 4'h4};

        // Reset state with a fetch present.
        idle_writes();
        rd_valid = 2'b01; rd_pc[0] = 32'h40; rd_pc[1] = 32'h44;
        #1 reset = 1'b1;
        #1;
        check("reset pred_taken", 32'(pred_taken), 32'h0);
        check("reset pred_target0", pred_target[0], 32'h0);
        check("reset ghr", 32'(ghr), 32'h0);
        check("reset pred_valid 01", 32'(pred_valid), 32'h1);
        rd_valid = 2'b11;
        #1;
        check("reset pred_valid 11", 32'(pred_valid), 32'h3);
        @(posedge clock); #1;
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            rd_valid      = vecs[i].rd_valid;
            rd_pc[0]      = vecs[i].pc0;
            rd_pc[1]      = vecs[i].pc1;
            wr_en         = vecs[i].wr_en;
            wr_pc         = vecs[i].wr_pc;
            wr_target     = vecs[i].wr_target;
            wr_bhr        = vecs[i].wr_bhr;
            wr_taken      = vecs[i].wr_taken;
            wr_mispredict = vecs[i].wr_mis;
            #2;
            check($sformatf("v%0d pred_valid", i), 32'(pred_valid), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d pred_taken", i), 32'(pred_taken), 32'(vecs[i].exp_taken));
            check($sformatf("v%0d pred_target0", i), pred_target[0], vecs[i].exp_tgt0);
            check($sformatf("v%0d pred_target1", i), pred_target[1], vecs[i].exp_tgt1);
            check($sformatf("v%0d pred_bhr0", i), 32'(pred_bhr[0]), 32'(vecs[i].exp_bhr0));
            check($sformatf("v%0d pred_bhr1", i), 32'(pred_bhr[1]), 32'(vecs[i].exp_bhr1));
            @(posedge clock); #1;
            check($sformatf("v%0d next ghr", i), 32'(ghr), 32'(vecs[i].exp_ghr_next));
        end

        // Mid-cycle reset after training: everything clears without an edge.
        idle_writes();
        rd_valid = 2'b11; rd_pc[0] = 32'h40; rd_pc[1] = 32'h48;
        #2;
        check("pre-reset pred_target0", pred_target[0], 32'h100);
        check("pre-reset ghr", 32'(ghr), 32'h4);
        reset = 1'b1;
        #1;
        check("async reset ghr", 32'(ghr), 32'h0);
        check("async reset pred_taken", 32'(pred_taken), 32'h0);
        check("async reset pred_target0", pred_target[0], 32'h0);
        check("async reset pred_target1", pred_target[1], 32'h0);
        check("async reset pred_valid", 32'(pred_valid), 32'h3);

        // Writes while reset is held must be ignored.
        wr_en = 1'b1; wr_pc = 32'h40; wr_target = 32'h100; wr_bhr = 4'h0; wr_taken = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("in-reset write pred_target0", pred_target[0], 32'h0);
        idle_writes();
        reset = 1'b0;
        #2;
        check("post-reset pred_target0", pred_target[0], 32'h0);
        check("post-reset pred_target1", pred_target[1], 32'h0);
        check("post-reset pred_taken", 32'(pred_taken), 32'h0);
        check("post-reset pred_valid", 32'(pred_valid), 32'h3);
        @(posedge clock); #1;
        check("post-reset next ghr", 32'(ghr), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/gshare_predictor.md
GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 SHALL take parameter N_LANES, default 2: prediction lanes per cycle, lane 0 oldest.
REQ-002 SHALL take parameter HIST_BITS, default `BRANCH_HISTORY_REG_SZ: global history width; PHT depth 2^HIST_BITS.
REQ-003 SHALL take parameter CTR_BITS, default 2: saturating counter width, legal range 1..4.
REQ-004 SHALL take parameter BTB_SETS, default 16: direct-mapped BTB entries, power of two.
REQ-005 SHALL have port: clock  in  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port: rd_valid  in  N_LANES  lane carries a fetched instruction.
REQ-008 SHALL have port: rd_pc  in  N_LANES x ADDR  PC per lane.
REQ-009 SHALL have port: pred_valid  out  N_LANES  lane valid and not squashed by an older taken prediction.
REQ-010 SHALL have port: pred_taken  out  N_LANES  predicted direction.
REQ-011 SHALL have port: pred_target  out  N_LANES x ADDR  BTB target; 0 on BTB miss.
REQ-012 SHALL have port: pred_bhr  out  N_LANES x HIST_BITS  history used to index this lane; carried down the pipe.
REQ-013 SHALL have port: wr_en  in  1  resolved branch update.
REQ-014 SHALL have ports: wr_pc, wr_target (ADDR), wr_bhr (HIST_BITS), wr_taken (1), wr_mispredict (1), all inputs.
REQ-015 SHALL have port: ghr  out  HIST_BITS  current speculative global history register.

Function
REQ-016 Lane index SHALL be rd_pc[HIST_BITS+1:2] XOR lane history; write index SHALL be wr_pc[HIST_BITS+1:2] XOR wr_bhr.
REQ-017 Lane 0 history SHALL be ghr; lane k history SHALL be lane k-1 history shifted left with lane k-1's pred_taken inserted at bit 0 if lane k-1 is a predicted branch, else unchanged.
REQ-018 A lane SHALL be a predicted branch when pred_valid is high and its BTB entry hits (valid and tag match).
REQ-019 pred_taken SHALL be counter MSB for BTB-hit lanes, 0 otherwise; prediction outputs SHALL be combinational (zero latency).
REQ-020 pred_valid[k] SHALL be rd_valid[k] AND no older lane with pred_valid and pred_taken high.
REQ-021 Next cycle ghr SHALL equal the history after the youngest pred_valid lane's contribution (one shift per predicted branch).
REQ-022 On wr_en the PHT counter at write index SHALL increment (wr_taken) or decrement, saturating at 2^CTR_BITS-1 and 0.
REQ-023 On wr_en with wr_taken high, the BTB set wr_pc[log2(BTB_SETS)+1:2] SHALL be written valid with tag = remaining upper PC bits and wr_target; not-taken updates SHALL leave the BTB unchanged.
REQ-024 On wr_en with wr_mispredict high, next ghr SHALL be {wr_bhr[HIST_BITS-2:0], wr_taken}, overriding any same-cycle speculative shift.
REQ-025 Same-cycle read and write to one PHT/BTB entry SHALL return the pre-update value; update visible next cycle.
REQ-026 wr_mispredict without wr_en SHALL be ignored.

Reset
REQ-027 Asserting reset SHALL immediately clear ghr to 0, all BTB valid bits to 0, and all counters to weakly not-taken (2^(CTR_BITS-1)-1).
REQ-028 During reset pred_taken SHALL be 0, pred_target 0, pred_valid equal to rd_valid; wr_en SHALL be ignored.

Structure
REQ-029 ADDR and default history sizes SHALL come from sys_defs.svh; a BTB entry struct (valid, tag, target) SHALL be defined in the shared package.
REQ-030 The BTB SHALL be one sub-module gshare_btb with N_LANES read ports and one write port; PHT counters SHALL be a flat register array in this module.

Verification (N_LANES=2, HIST_BITS=4, CTR_BITS=2, BTB_SETS=16)
REQ-031 Reset, read lane 0 pc 0x40 -> pred_taken 0, pred_target 0, ghr 0, pred_valid = rd_valid.
REQ-032 Two wr_en taken at pc 0x40, bhr 0, target 0x100 -> next read pc 0x40 with ghr 0 gives pred_taken 1, target 0x100; third taken update keeps counter 3.
REQ-033 Lanes 0x40 (trained taken), 0x44 both valid -> pred_valid = 01, ghr becomes 0001 next cycle.
REQ-034 Lane 0 BTB-hit not-taken, lane 1 BTB-hit taken, ghr 0011 -> lane 1 pred_bhr 0110, next ghr 1101.
REQ-035 wr_mispredict, wr_bhr 1010, wr_taken 1 with same-cycle predicted-taken fetch -> next ghr 0101.
REQ-036 Reset asserted mid-cycle after training -> outputs and ghr clear without a clock edge; prior entries miss afterwards.
